// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the pushbutton conditioning blocks.
//   btn_state_e : 2-bit debounce FSM encoding (ST_IDLE, ST_PRESS_WAIT,
//                 ST_HELD, ST_RELEASE_WAIT), reusable by other button blocks.
//   max2        : elaboration-time helper for sizing shared counters.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
//   clk  : destination clock
//   rst  : asynchronous, active-low reset; both flops load RST_VAL
//   d    : asynchronous input
//   q    : synchronised output (two clk edges of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: turns one raw, bouncy, active-low button pin into
// single-cycle press / release strobes and a stable debounced level.
//
// Ports
//   clk            : system clock
//   rst            : asynchronous, active-low reset
//   btn_in         : raw button pin, low = pressed, asynchronous to clk
//   press          : one-cycle strobe per accepted press (and per auto-repeat)
//   release_strobe : one-cycle strobe per accepted release
//                    (named this way because `release` is a reserved word)
//   btn_level      : debounced level, 1 = pressed
//
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat press strobes
// while the button stays held (REPEAT_DELAY, then every REPEAT_RATE cycles).
// Without it the REPEAT_* parameters are unused.
//
// Latency: a raw edge captured at clk edge k produces a strobe in the cycle
// after edge k+DB_CYCLES+2 (2 synchroniser edges + entry edge + DB_CYCLES-1
// counting edges). All outputs are registered.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int DB_CYCLES    = 120000,
  parameter int REPEAT_DELAY = 6000000,
  parameter int REPEAT_RATE  = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic release_strobe,
  output logic btn_level
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam int RPT_MAX = max2(REPEAT_DELAY, REPEAT_RATE);

  // Synchroniser resets to 1 so reset looks like "released".
  logic sync_out;
  logic p;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_out)
  );

  assign p = ~sync_out;

  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt, release_nxt, level_nxt;
  logic          rpt_fire;

`ifdef BTN_REPEAT_EN
  localparam int RW = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rpt;
  logic          rpt_first;  // still waiting for the initial (longer) delay

  // Fires only while staying in HELD; leaving HELD takes priority.
  assign rpt_fire = (state == ST_HELD) && p &&
                    (rpt == (rpt_first ? DELAY_LAST : RATE_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt       <= '0;
      rpt_first <= 1'b1;
    end else if (state_nxt == ST_HELD && state != ST_HELD) begin
      // Every entry into HELD (fresh press or bounce back) restarts the delay.
      rpt       <= '0;
      rpt_first <= 1'b1;
    end else if (state == ST_HELD) begin
      if (rpt_fire) begin
        rpt       <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt <= rpt + 1'b1;
      end
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = (RPT_MAX > 0);
  assign rpt_fire   = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (p) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!p) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!p) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end else begin
          press_nxt = rpt_fire;
        end
      end
      ST_RELEASE_WAIT: begin
        if (p) begin
          state_nxt = ST_HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
    level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
      btn_level      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      press          <= press_nxt;
      release_strobe <= release_nxt;
      btn_level      <= level_nxt;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DB_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=5). Tick index 1 of a watch window is the first clk edge after
// the stimulus change, so an accepted change strobes on tick 7.
module tb_button_debouncer;

`ifdef BTN_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b1;
  logic press, rel, level;

  int n_chk = 0;
  int n_pass = 0;
  int np, nr, nl, fp, fr, lp, both;

  button_debouncer #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_in         (btn_in),
    .press          (press),
    .release_strobe (rel),
    .btn_level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Run n edges, sampling 1 time unit after each edge.
  task automatic watch(input int n);
    np = 0; nr = 0; nl = 0; fp = 0; fr = 0; lp = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (press) begin np++; if (fp == 0) fp = i; lp = i; end
      if (rel)   begin nr++; if (fr == 0) fr = i; end
      if (level) nl++;
      if (press && rel) both++;
    end
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    both = 0;
    // Reset state
    #12;
    chk("rst_press", int'(press), 0);
    chk("rst_rel", int'(rel), 0);
    chk("rst_level", int'(level), 0);
    edge1(); rst = 1'b1;
    watch(3);
    chk("idle_quiet", np + nr + nl, 0);

    // 1: clean press held 20 cycles, then release
    btn_in = 1'b0; watch(20);
    chk("t1_np", np, 1 + REP);
    chk("t1_fp", fp, 7);
    chk("t1_level", nl, 14);
    chk("t1_nr", nr, 0);
    btn_in = 1'b1; watch(12);
    chk("t1_nr_rel", nr, 1);
    chk("t1_fr", fr, 7);
    chk("t1_np_rel", np, REP);
    chk("t1_level_rel", nl, 6);

    // 2: short glitches never accepted
    btn_in = 1'b0; watch(3);
    chk("t2_a", np + nr + nl, 0);
    btn_in = 1'b1; watch(2);
    chk("t2_b", np + nr + nl, 0);
    btn_in = 1'b0; watch(3);
    chk("t2_c", np + nr + nl, 0);
    btn_in = 1'b1; watch(10);
    chk("t2_d", np + nr + nl, 0);

    // 3: bounce while held
    btn_in = 1'b0; watch(8);
    chk("t3_press", np, 1);
    chk("t3_fp", fp, 7);
    btn_in = 1'b1; watch(2);
    chk("t3_lvl_a", nl, 2);
    btn_in = 1'b0; watch(15);
    chk("t3_nr", nr, 0);
    chk("t3_lvl_b", nl, 15);
    chk("t3_np", np, REP);
    btn_in = 1'b1; watch(10);
    chk("t3_rel", nr, 1);
    chk("t3_fr", fr, 7);
    chk("t3_np_rel", np, 0);

    // 4: reset during PRESS_WAIT, then during HELD
    btn_in = 1'b0; watch(4);
    chk("t4_pw", np + nl, 0);
    rst = 1'b0; #2;
    chk("t4_rst_out", int'(press) + int'(rel) + int'(level), 0);
    btn_in = 1'b1;
    edge1(); rst = 1'b1;
    watch(12);
    chk("t4_after", np + nr + nl, 0);
    btn_in = 1'b0; watch(10);
    chk("t4_held_np", np, 1);
    chk("t4_held_lvl", nl, 4);
    rst = 1'b0; #2;
    chk("t4_async_lvl", int'(level), 0);
    btn_in = 1'b1;
    edge1(); rst = 1'b1;
    watch(12);
    chk("t4_after2", np + nr + nl, 0);

    // 5: button held through reset release
    edge1(); rst = 1'b0; btn_in = 1'b0;
    edge1(); edge1(); rst = 1'b1;
    watch(12);
    chk("t5_np", np, 1);
    chk("t5_fp", fp, 7);
    btn_in = 1'b1; watch(10);
    chk("t5_nr", nr, 1);
    chk("t5_np_rel", np, 0);

    // 6: long hold (auto-repeat when enabled)
    btn_in = 1'b0; watch(30);
    chk("t6_np", np, (REP != 0) ? 4 : 1);
    chk("t6_fp", fp, 7);
    chk("t6_lp", lp, (REP != 0) ? 27 : 7);
    btn_in = 1'b1; watch(10);
    chk("t6_np_rel", np, REP);
    chk("t6_nr", nr, 1);
    chk("t6_fr", fr, 7);

    chk("no_overlap", both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
